// File: rtl/crc32_frame_arbiter.sv
// rtl/crc32_frame_arbiter.sv - frame-granular round-robin arbiter in front of one shared CRC-32 engine
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/data/last/ready per-requester byte streams (lane i = req_data[8i+7:8i])
//   eng_rst/load/finish/data  registered strobes and data into the CRC engine
//   eng_crc                   serial CRC byte from the engine, most significant byte first
//   res_valid/ready/crc/id    32-bit CRC result tagged with the owning requester
//   busy                      high whenever a frame is in flight or a result is pending
module crc32_frame_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int CRC_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic                eng_rst,
    output logic                eng_load,
    output logic                eng_finish,
    output logic [7:0]          eng_data,
    input  logic [7:0]          eng_crc,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [31:0]         res_crc,
    output logic [IDW-1:0]      res_id,
    output logic                busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = PW + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ERST    = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_FINISH  = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_COLLECT = 3'd5;
    localparam logic [2:0] S_RESULT  = 3'd6;

    logic [2:0]    state;
    // grant doubles as the round-robin pointer: the search starts one past it.
    logic [PW-1:0] grant;
    logic [PW-1:0] pick;
    logic          found;
    logic [1:0]    cnt;

    logic          sel_valid;
    logic          sel_last;
    logic [7:0]    sel_data;

    always_comb begin : grant_search
        logic [CW-1:0] cand;
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = CW'(grant) + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!found && req_valid[cand[PW-1:0]]) begin
                found = 1'b1;
                pick  = cand[PW-1:0];
            end
        end
    end

    assign sel_valid = req_valid[grant];
    assign sel_last  = req_last[grant];
    assign sel_data  = req_data[{grant, 3'b000} +: 8];

    // Ready is only offered to the owner while streaming, so it drops in the
    // same cycle the state leaves STREAM after the last byte.
    assign req_ready = (state == S_STREAM) ? (NREQ'(1) << grant) : '0;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= PW'(NREQ - 1);
            cnt        <= '0;
            eng_rst    <= 1'b0;
            eng_load   <= 1'b0;
            eng_finish <= 1'b0;
            eng_data   <= '0;
            res_valid  <= 1'b0;
            res_crc    <= '0;
            res_id     <= '0;
        end else begin
            eng_rst    <= 1'b0;
            eng_load   <= 1'b0;
            eng_finish <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant   <= pick;
                        res_id  <= IDW'(pick);
                        eng_rst <= 1'b1;
                        state   <= S_ERST;
                    end
                end
                S_ERST: begin
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (sel_valid) begin
                        eng_load <= 1'b1;
                        eng_data <= sel_data;
                        if (sel_last) begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    // Two cycles: the one carrying the last load, then the finish strobe.
                    if (!eng_finish) begin
                        eng_finish <= 1'b1;
                    end else begin
                        cnt   <= '0;
                        state <= (CRC_LAT > 1) ? S_WAIT : S_COLLECT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 2'(CRC_LAT - 2)) begin
                        cnt   <= '0;
                        state <= S_COLLECT;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_COLLECT: begin
                    res_crc <= {res_crc[23:0], eng_crc};
                    if (cnt == 2'd3) begin
                        res_valid <= 1'b1;
                        state     <= S_RESULT;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_frame_arbiter.sv
// tb/tb_crc32_frame_arbiter.sv - directed self-checking bench for crc32_frame_arbiter
module tb_crc32_frame_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int CRC_LAT = 3;
    // Engine model emits {cycles since eng_finish, 4'hB}; samples at distances 3..6.
    localparam logic [31:0] EXP_CRC = 32'h3B4B5B6B;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              eng_rst;
    logic              eng_load;
    logic              eng_finish;
    logic [7:0]        eng_data;
    logic [7:0]        eng_crc;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_crc;
    logic [IDW-1:0]    res_id;
    logic              busy;

    always #5 clk = ~clk;

    crc32_frame_arbiter #(.NREQ(NREQ), .IDW(IDW), .CRC_LAT(CRC_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .eng_rst(eng_rst), .eng_load(eng_load), .eng_finish(eng_finish), .eng_data(eng_data),
        .eng_crc(eng_crc),
        .res_valid(res_valid), .res_ready(res_ready), .res_crc(res_crc), .res_id(res_id),
        .busy(busy)
    );

    logic [3:0] since_fin = 4'd0;
    always @(posedge clk or posedge rst) begin
        if (rst) since_fin <= 4'd0;
        else if (eng_finish) since_fin <= 4'd1;
        else if (since_fin != 4'd0 && since_fin != 4'd15) since_fin <= since_fin + 4'd1;
    end
    assign eng_crc = {since_fin, 4'hB};

    int n_cmp, n_bad;

    logic [8:0] fifo [4][16];
    int head [4], tail [4], hold [4], gap_idx [4], gap_len [4];

    int cyc, n_rst, n_fin, n_ld, n_res, rst_cyc, fin_cyc, res_rise_cyc, viol;
    logic [7:0]     ld_data [32];
    int             ld_cyc [32];
    logic [IDW-1:0] res_ids [16];
    logic [31:0]    res_crcs [16];
    logic           prev_res_valid;
    logic [3:0]     ready_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_fifos();
        for (int r = 0; r < 4; r++) begin
            head[r] = 0; tail[r] = 0; hold[r] = 0; gap_idx[r] = -1; gap_len[r] = 0;
        end
    endtask

    task automatic clear_logs();
        n_rst = 0; n_fin = 0; n_ld = 0; n_res = 0; rst_cyc = 0; fin_cyc = 0;
        res_rise_cyc = 0; viol = 0; prev_res_valid = 1'b0; ready_seen = '0;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        fifo[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    task automatic drive();
        for (int r = 0; r < 4; r++) begin
            if (head[r] < tail[r] && hold[r] == 0) begin
                req_valid[r] = 1'b1;
                req_last[r]  = fifo[r][head[r]][8];
                req_data[8*r +: 8] = fifo[r][head[r]][7:0];
            end else begin
                req_valid[r] = 1'b0;
                req_last[r]  = 1'b0;
                req_data[8*r +: 8] = 8'h00;
            end
        end
    endtask

    // Observe the current cycle, cross one rising edge, then update the sources.
    task automatic tick();
        logic [3:0] acc;
        if (eng_rst) begin n_rst++; rst_cyc = cyc; end
        if (eng_finish) begin n_fin++; fin_cyc = cyc; end
        if (eng_load && n_ld < 32) begin ld_data[n_ld] = eng_data; ld_cyc[n_ld] = cyc; n_ld++; end
        if ($countones(req_ready) > 1) viol++;
        if (eng_load && eng_finish) viol++;
        if (eng_rst && (eng_load || eng_finish)) viol++;
        ready_seen = ready_seen | req_ready;
        if (res_valid && !prev_res_valid) res_rise_cyc = cyc;
        prev_res_valid = res_valid;
        if (res_valid && res_ready && n_res < 16) begin
            res_ids[n_res] = res_id; res_crcs[n_res] = res_crc; n_res++;
        end
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < 4; r++) begin
            if (hold[r] > 0) hold[r]--;
            if (acc[r]) begin
                if (head[r] == gap_idx[r]) hold[r] = gap_len[r];
                head[r]++;
            end
        end
        drive();
    endtask

    task automatic run_until(input string tag, input int want, input int budget);
        int k;
        k = 0;
        while (n_res < want && k < budget) begin
            tick();
            k++;
        end
        chk(tag, n_res, want);
    endtask

    initial begin
        int k, bad;
        logic [31:0] hold_crc;
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1'b1; res_ready = 1'b1;
        clear_fifos(); clear_logs(); drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_eng_strobes", {29'd0, eng_rst, eng_load, eng_finish}, 0);
        chk("rst_eng_data", 32'(eng_data), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_crc", res_crc, 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // 1: basic 3-byte frame from requester 0
        push(0, 8'hA5, 1'b0); push(0, 8'h3C, 1'b0); push(0, 8'h7E, 1'b1); drive();
        run_until("t1_done", 1, 80);
        chk("t1_n_rst", n_rst, 1);
        chk("t1_n_ld", n_ld, 3);
        chk("t1_ld0", 32'(ld_data[0]), 32'hA5);
        chk("t1_ld1", 32'(ld_data[1]), 32'h3C);
        chk("t1_ld2", 32'(ld_data[2]), 32'h7E);
        chk("t1_rst_to_load", ld_cyc[0] - rst_cyc, 2);
        chk("t1_load_run", ld_cyc[2] - ld_cyc[0], 2);
        chk("t1_n_fin", n_fin, 1);
        chk("t1_fin_after_load", fin_cyc - ld_cyc[2], 1);
        chk("t1_res_latency", res_rise_cyc - fin_cyc, 7);
        chk("t1_res_id", 32'(res_ids[0]), 0);
        chk("t1_res_crc", res_crcs[0], EXP_CRC);
        chk("t1_idle_valid", 32'(res_valid), 0);
        chk("t1_idle_busy", 32'(busy), 0);

        // 2: all four requesters busy, two 2-byte frames each
        rst = 1'b1; #2; rst = 1'b0;
        clear_logs();
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 4; r++) begin
                push(r, 8'(16*r + 2*f), 1'b0);
                push(r, 8'(16*r + 2*f + 1), 1'b1);
            end
        end
        drive();
        run_until("t2_done", 8, 400);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_grant%0d", i), 32'(res_ids[i]), i % 4);
        end
        chk("t2_n_ld", n_ld, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_ld%0d", i), 32'(ld_data[i]), 16*((i/2) % 4) + 2*(i/8) + (i % 2));
        end
        chk("t2_n_rst", n_rst, 8);
        chk("t2_res_crc", res_crcs[7], EXP_CRC);
        chk("t2_violations", viol, 0);

        // 3: requester 2 pauses two cycles after its first byte
        clear_logs();
        gap_idx[2] = head[2]; gap_len[2] = 2;
        push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b0); push(2, 8'hC3, 1'b1); drive();
        run_until("t3_done", 1, 80);
        gap_idx[2] = -1;
        chk("t3_n_ld", n_ld, 3);
        chk("t3_ld0", 32'(ld_data[0]), 32'hC1);
        chk("t3_ld1", 32'(ld_data[1]), 32'hC2);
        chk("t3_ld2", 32'(ld_data[2]), 32'hC3);
        chk("t3_gap", ld_cyc[1] - ld_cyc[0], 3);
        chk("t3_tail", ld_cyc[2] - ld_cyc[1], 1);
        chk("t3_fin", fin_cyc - ld_cyc[2], 1);
        chk("t3_ready_seen", 32'(ready_seen), 32'h4);
        chk("t3_res_id", 32'(res_ids[0]), 2);

        // 4: single-byte frame
        clear_logs();
        push(3, 8'hFF, 1'b1); drive();
        run_until("t4_done", 1, 80);
        chk("t4_n_ld", n_ld, 1);
        chk("t4_ld0", 32'(ld_data[0]), 32'hFF);
        chk("t4_n_rst", n_rst, 1);
        chk("t4_fin", fin_cyc - ld_cyc[0], 1);
        chk("t4_res_latency", res_rise_cyc - fin_cyc, 7);
        chk("t4_res_crc", res_crcs[0], EXP_CRC);
        chk("t4_res_id", 32'(res_ids[0]), 3);

        // 5: result back-pressure while requester 1 waits
        clear_logs();
        res_ready = 1'b0;
        push(0, 8'h55, 1'b1); drive();
        k = 0;
        while (!res_valid && k < 80) begin tick(); k++; end
        chk("t5_res_valid", 32'(res_valid), 1);
        hold_crc = res_crc;
        push(1, 8'h66, 1'b1); drive();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_crc !== hold_crc || res_id !== 2'd0 || busy !== 1'b1 ||
                req_ready !== 4'b0000 || res_valid !== 1'b1) bad++;
        end
        chk("t5_stall_cycles", bad, 0);
        chk("t5_res_id", 32'(res_id), 0);
        chk("t5_res_crc", res_crc, EXP_CRC);
        res_ready = 1'b1;
        tick();
        chk("t5_post_valid", 32'(res_valid), 0);
        chk("t5_post_busy", 32'(busy), 0);
        tick();
        chk("t5_regrant_rst", 32'(eng_rst), 1);
        chk("t5_regrant_id", 32'(res_id), 1);
        run_until("t5_done", 2, 80);
        chk("t5_res_id1", 32'(res_ids[1]), 1);

        // 6: reset in the middle of a 5-byte frame
        clear_logs();
        for (int i = 1; i <= 5; i++) push(0, 8'(i), i == 5);
        drive();
        k = 0;
        while (n_ld < 2 && k < 60) begin tick(); k++; end
        chk("t6_two_loaded", n_ld, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_ready", 32'(req_ready), 0);
        chk("t6_async_strobes", {29'd0, eng_rst, eng_load, eng_finish}, 0);
        chk("t6_async_data", 32'(eng_data), 0);
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_res_valid", 32'(res_valid), 0);
        clear_fifos(); drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        push(0, 8'h11, 1'b1); push(1, 8'h22, 1'b1); drive();
        run_until("t6_done", 2, 120);
        repeat (10) tick();
        chk("t6_n_res", n_res, 2);
        chk("t6_first_id", 32'(res_ids[0]), 0);
        chk("t6_second_id", 32'(res_ids[1]), 1);
        chk("t6_first_load", 32'(ld_data[0]), 32'h11);
        chk("t6_violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
